// File: rtl/extender_pkg.sv
// extender_pkg: op codes and occupancy states shared by decode and extender_pipe.
// Optional illegal-op trap is selected with EXTENDER_ILLEGAL_TRAP_EN.
package extender_pkg;

  localparam logic [2:0] EXT_ZERO   = 3'b000;
  localparam logic [2:0] EXT_SIGN   = 3'b001;
  localparam logic [2:0] EXT_UPPER  = 3'b010;
  localparam logic [2:0] EXT_BRANCH = 3'b011;
  localparam logic [2:0] EXT_BYTE   = 3'b100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ext_state_t;

  function automatic logic ext_op_legal(
    input logic [2:0] op
  );
    return op <= EXT_BYTE;
  endfunction

endpackage

// File: rtl/extender_pipe_if.sv
// extender_pipe_if: input and output valid/ready bundles of the extender.
// out_err exists only when EXTENDER_ILLEGAL_TRAP_EN is defined.
interface extender_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_ops;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
  logic             out_err;

  modport master (
    output in_valid, in_data, in_ops,
    output out_ready,
    input  in_ready, out_valid,
    input  out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_ops,
    input  out_ready,
    output in_ready, out_valid,
    output out_data, out_err
  );
`else
  modport master (
    output in_valid, in_data, in_ops,
    output out_ready,
    input  in_ready, out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid, in_data, in_ops,
    input  out_ready,
    output in_ready, out_valid,
    output out_data
  );
`endif

endinterface

// File: rtl/extender_core.sv
// extender_core: combinational op -> extended immediate function.
// EXTENDER_ILLEGAL_TRAP_EN adds o_err and zeroes illegal results.
module extender_core
  import extender_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_data,
  input  logic [2:0]       i_ops,
`ifdef EXTENDER_ILLEGAL_TRAP_EN
  output logic             o_err,
`endif
  output logic [OUT_W-1:0] o_data
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_byte;

  assign w_zero   = {{PAD{1'b0}}, i_data};
  assign w_sign   = {{PAD{i_data[IN_W-1]}}, i_data};
  assign w_upper  = {i_data, {PAD{1'b0}}};
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};
  assign w_byte   = {{(OUT_W-8){i_data[7]}}, i_data[7:0]};

  // select the extension for the current op
  always_comb begin
    o_data = '0;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
    o_err  = 1'b0;
`endif
    unique case (1'b1)
      (i_ops == EXT_ZERO):   o_data = w_zero;
      (i_ops == EXT_SIGN):   o_data = w_sign;
      (i_ops == EXT_UPPER):  o_data = w_upper;
      (i_ops == EXT_BRANCH): o_data = w_branch;
      (i_ops == EXT_BYTE):   o_data = w_byte;
      default: begin
`ifdef EXTENDER_ILLEGAL_TRAP_EN
        o_data = '0;
        o_err  = 1'b1;
`else
        o_data = w_zero;
`endif
      end
    endcase
  end

endmodule

// File: rtl/extender_pipe.sv
// extender_pipe: registered immediate extender with 2-entry skid buffer.
// EXTENDER_ILLEGAL_TRAP_EN enables the out_err illegal-op flag.
module extender_pipe
  import extender_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic clk,
  input  logic reset,
  extender_pipe_if.slave bus
);

  ext_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_main_data;
  logic [OUT_W-1:0] r_skid_data;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
  logic             r_main_err;
  logic             r_skid_err;
  logic             w_err;
`endif

  logic [OUT_W-1:0] w_res;
  logic             w_in_xfer;
  logic             w_out_xfer;

  extender_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_data (bus.in_data),
    .i_ops  (bus.in_ops),
`ifdef EXTENDER_ILLEGAL_TRAP_EN
    .o_err  (w_err),
`endif
    .o_data (w_res)
  );

  // reset masks both handshakes so nothing moves in the reset cycle
  assign bus.in_ready  = r_in_ready & ~reset;
  assign bus.out_valid = r_out_valid & ~reset;
  assign bus.out_data  = r_main_data;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
  assign bus.out_err   = r_main_err;
`endif

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // occupancy FSM: main holds the head beat, skid the follower
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_skid_data <= '0;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
      r_main_err  <= 1'b0;
      r_skid_err  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main_data <= w_res;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
            r_main_err  <= w_err;
`endif
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main_data <= w_res;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
            r_main_err  <= w_err;
`endif
          end else if (w_in_xfer) begin
            r_skid_data <= w_res;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
            r_skid_err  <= w_err;
`endif
            r_in_ready  <= 1'b0;
            r_state     <= TWO;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            r_main_data <= r_skid_data;
            r_skid_data <= '0;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
            r_main_err  <= r_skid_err;
            r_skid_err  <= 1'b0;
`endif
            r_in_ready  <= 1'b1;
            r_state     <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extender_pipe.sv
// tb_extender_pipe: directed and random checks of extender_pipe
// against an arithmetic reference model and a scoreboard queue.
module tb_extender_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  extender_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  extender_pipe #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [2:0]  op,
    input logic [15:0] d
  );
    int s16;
    int s8;
    logic [7:0] lo;
    lo  = d[7:0];
    s16 = $signed(d);
    s8  = $signed(lo);
    case (op)
      3'd0: return {16'h0000, d};
      3'd1: return s16;
      3'd2: return {d, 16'h0000};
      3'd3: return s16 * 4;
      3'd4: return s8;
`ifdef EXTENDER_ILLEGAL_TRAP_EN
      default: return 32'h0;
`else
      default: return {16'h0000, d};
`endif
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] op);
`ifdef EXTENDER_ILLEGAL_TRAP_EN
    return op > 3'd4;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp);
`ifdef EXTENDER_ILLEGAL_TRAP_EN
    chk1(tag, bus.out_err, exp);
`else
    if (exp) chk1(tag, 1'b0, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one beat in, then its result checked the following cycle
  task automatic send_check(
    input string tag,
    input logic [2:0] op,
    input logic [15:0] d,
    input logic [31:0] exp,
    input logic exp_err
  );
    bus.in_valid  = 1'b1;
    bus.in_ops    = op;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1({tag, "_valid"}, bus.out_valid, 1'b1);
    chk32({tag, "_data"}, bus.out_data, exp);
    chk_err({tag, "_err"}, exp_err);
    tick();
  endtask

  logic [15:0] sd[8];
  logic [2:0]  so[8];
  logic [32:0] q[$];

  initial begin
    int k;
    int acc;
    int got;
    int cyc;
    logic took;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_err;
    logic [32:0] head;
    logic cur_err;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ops    = '0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_out_data", bus.out_data, 32'h0);
    chk_err("rst_out_err", 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);
    tick();

    // directed ops
    send_check("sign", 3'b001, 16'h8001, 32'hFFFF8001, 1'b0);
    send_check("zero", 3'b000, 16'h8001, 32'h00008001, 1'b0);
    send_check("upper", 3'b010, 16'h1234, 32'h12340000, 1'b0);
    send_check("branch", 3'b011, 16'hFFFF, 32'hFFFFFFFC, 1'b0);
    send_check("byte", 3'b100, 16'h1280, 32'hFFFFFF80, 1'b0);
`ifdef EXTENDER_ILLEGAL_TRAP_EN
    send_check("illegal", 3'b110, 16'hABCD, 32'h0, 1'b1);
`else
    send_check("illegal", 3'b110, 16'hABCD, 32'h0000ABCD, 1'b0);
`endif

    // stall stream: 8 beats, only 2 fit while out_ready=0
    for (int i = 0; i < 8; i++) begin
      sd[i] = 16'($urandom);
      so[i] = 3'($urandom_range(0, 4));
    end
    k = 0;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = sd[k];
      bus.in_ops   = so[k];
      @(negedge clk);
      took = bus.in_ready;
      tick();
      if (took) begin
        acc++;
        k++;
      end
    end
    chk32("stall_accepted", 32'(acc), 32'd2);
    chk1("stall_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bus.in_valid = (k < 8);
      bus.in_data  = sd[k % 8];
      bus.in_ops   = so[k % 8];
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      chk1("stream_valid", bus.out_valid, 1'b1);
      chk32("stream_data", bus.out_data, model(so[j], sd[j]));
      tick();
      if (took) k++;
    end
    bus.in_valid = 1'b0;
    chk32("stream_all_in", 32'(k), 32'd8);
    @(negedge clk);
    chk1("stream_drained", bus.out_valid, 1'b0);
    tick();

    // random traffic against scoreboard
    q.delete();
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_err = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_ops    = 3'($urandom_range(0, 7));
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
`ifdef EXTENDER_ILLEGAL_TRAP_EN
      cur_err = bus.out_err;
`else
      cur_err = 1'b0;
`endif
      if (prev_stall) begin
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk32("hold_data", bus.out_data, prev_data);
        chk1("hold_err", cur_err, prev_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk1("rand_spurious", 1'b1, 1'b0);
        end else begin
          head = q.pop_front();
          chk32("rand_data", bus.out_data, head[31:0]);
          chk1("rand_err", cur_err, head[32]);
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back({model_err(bus.in_ops),
                     model(bus.in_ops, bus.in_data)});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_err   = cur_err;
      tick();
      cyc++;
    end
    chk32("rand_beats", 32'(got), 32'd1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid && q.size() != 0) begin
        head = q.pop_front();
        chk32("drain_data", bus.out_data, head[31:0]);
      end
      tick();
    end
    chk32("drain_left", 32'(q.size()), 32'd0);

    // reset with both entries occupied
    bus.out_ready = 1'b0;
    bus.in_ops    = 3'b001;
    bus.in_data   = 16'h5555;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_data   = 16'h6666;
    tick();
    chk1("two_in_ready", bus.in_ready, 1'b0);
    chk1("two_out_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("rst2_valid_in_cycle", bus.out_valid, 1'b0);
    chk1("rst2_ready_in_cycle", bus.in_ready, 1'b0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("rst2_out_valid", bus.out_valid, 1'b0);
    chk32("rst2_out_data", bus.out_data, 32'h0);
    chk1("rst2_in_ready", bus.in_ready, 1'b1);
    tick();
    send_check("fresh", 3'b000, 16'h00AA, 32'h000000AA, 1'b0);
    @(negedge clk);
    chk1("fresh_only", bus.out_valid, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
